fmadd_norm_round: RTL and testbench

- Stage directly downstream of the FMADD leading-zero detector.
- Consumes the unnormalized 32-bit FMA magnitude, its biased exponent and sign, plus the LZD's 5-bit leading-zero count.
- Left-normalizes, adjusts the exponent, rounds to nearest-even and packs a bfloat16 result with exception flags.
- 2-stage pipeline with valid/ready handshake; feeds the FPU result mux.

---
 rtl/fmadd_pkg.sv | 27 ++
 rtl/fmadd_rne_round.sv | 19 +
 rtl/fmadd_norm_round.sv | 182 ++++++++++++++++++
 tb/tb_fmadd_norm_round.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fmadd_pkg.sv
// Shared FMADD back-end types: bf16 encoding, exception flag bundle and exponent limits.
package fmadd_pkg;

  localparam int BF16_EXP_MAX = 255;
  localparam int BF16_BIAS    = 127;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] mant;
  } bf16_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;

  function automatic bf16_t bf16_zero(input logic sign);
    return '{sign: sign, exp: 8'h00, mant: 7'h00};
  endfunction

  function automatic bf16_t bf16_inf(input logic sign);
    return '{sign: sign, exp: 8'hFF, mant: 7'h00};
  endfunction

endpackage

// File: rtl/fmadd_rne_round.sv
// Round-to-nearest-even on a 7-bit bf16 fraction with guard/round/sticky; reports carry-out and inexact.
module fmadd_rne_round (
  input  logic [6:0] mant,
  input  logic       g,
  input  logic       r,
  input  logic       s,
  output logic [6:0] mant_rnd,
  output logic       carry,
  output logic       inexact
);

  logic inc;

  // Ties go up only when the kept LSB is odd.
  assign inc                = g & (r | s | mant[0]);
  assign {carry, mant_rnd}  = {1'b0, mant} + {7'd0, inc};
  assign inexact            = g | r | s;

endmodule

// File: rtl/fmadd_norm_round.sv
// FMADD normalize/round/pack stage: 2-stage valid/ready pipe producing bf16 plus flags.
// Define FMADD_NORM_SUBNORM_EN to produce subnormals instead of flushing small results to zero.
module fmadd_norm_round
  import fmadd_pkg::*;
#(
  parameter int MAG_W = 32,
  parameter int EXP_W = 10,
  parameter int BIAS  = 127
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [MAG_W-1:0]        in_mag,
  input  logic [4:0]              in_lzc,
  input  logic                    in_special,
  input  logic [15:0]             in_special_val,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_result,
  output logic                    out_overflow,
  output logic                    out_underflow,
  output logic                    out_inexact
);

  localparam logic signed [EXP_W-1:0] E_MAX  = EXP_W'(BF16_EXP_MAX);
  localparam logic signed [EXP_W-1:0] E_ZERO = '0;
  localparam logic signed [EXP_W-1:0] E_ONE  = EXP_W'(1);

  logic [2:1] vld_pipe;
  logic       s1_adv;

  logic                    st1_zero;
  logic [MAG_W-1:0]        st1_sh;
  logic signed [EXP_W-1:0] st1_e;

  logic                    s1_sign;
  logic                    s1_zero;
  logic                    s1_special;
  logic [15:0]             s1_sval;
  logic [MAG_W-1:0]        s1_sh;
  logic signed [EXP_W-1:0] s1_e;

  logic [6:0]              rn_mant;
  logic                    rn_g, rn_r, rn_s;
  logic [6:0]              rn_mant_rnd;
  logic                    rn_carry, rn_inexact;
  logic signed [EXP_W-1:0] e_post;

  bf16_t  res_d;
  flags_t flg_d;
  logic   norm_sel;

  assign s1_adv    = !vld_pipe[2] || out_ready;
  assign in_ready  = !vld_pipe[1] || s1_adv;
  assign out_valid = vld_pipe[2];

  // Stage 1: zero is decided from the magnitude itself so a bad lzc cannot mask it.
  assign st1_zero = (in_mag == '0);
  assign st1_sh   = in_mag << in_lzc;
  assign st1_e    = in_exp + E_ONE - EXP_W'(in_lzc);

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_sign    <= in_sign;
      s1_zero    <= st1_zero;
      s1_special <= in_special;
      s1_sval    <= in_special_val;
      s1_sh      <= st1_sh;
      s1_e       <= st1_e;
    end
  end

  // Stage 2: hidden bit at MSB, 7 kept fraction bits, then guard/round/sticky.
  assign rn_mant = s1_sh[MAG_W-2 -: 7];
  assign rn_g    = s1_sh[MAG_W-9];
  assign rn_r    = s1_sh[MAG_W-10];
  assign rn_s    = |s1_sh[MAG_W-11:0];

  fmadd_rne_round u_rnd (
    .mant     (rn_mant),
    .g        (rn_g),
    .r        (rn_r),
    .s        (rn_s),
    .mant_rnd (rn_mant_rnd),
    .carry    (rn_carry),
    .inexact  (rn_inexact)
  );

  assign e_post = s1_e + EXP_W'(rn_carry);

`ifdef FMADD_NORM_SUBNORM_EN
  localparam logic signed [EXP_W-1:0] E_SUB_MIN = EXP_W'(-7);

  logic [10:0] sub_x;
  logic [10:0] sub_mask;
  logic [9:0]  sub_sh;
  logic [3:0]  sub_k;
  logic        sub_sticky;
  logic        sub_range;
  logic [6:0]  sub_mant;
  logic        sub_carry, sub_inexact;

  // Denormalize the unrounded significand by 1-e; everything shifted out folds into sticky.
  assign sub_k      = 4'd1 - s1_e[3:0];
  assign sub_x      = {1'b1, rn_mant, rn_g, rn_r, rn_s};
  assign sub_sh     = 10'(sub_x >> sub_k);
  assign sub_mask   = (11'd1 << sub_k) - 11'd1;
  assign sub_sticky = sub_sh[0] | (|(sub_x & sub_mask));
  assign sub_range  = (s1_e >= E_SUB_MIN) && (s1_e <= E_ZERO);

  fmadd_rne_round u_sub_rnd (
    .mant     (sub_sh[9:3]),
    .g        (sub_sh[2]),
    .r        (sub_sh[1]),
    .s        (sub_sticky),
    .mant_rnd (sub_mant),
    .carry    (sub_carry),
    .inexact  (sub_inexact)
  );
`endif

  always_comb begin
    res_d    = '0;
    flg_d    = '0;
    norm_sel = 1'b0;
    if (s1_special) begin
      res_d = s1_sval;
    end else if (s1_zero) begin
      res_d = bf16_zero(s1_sign);
    end else if (e_post >= E_MAX) begin
      res_d          = bf16_inf(s1_sign);
      flg_d.overflow = 1'b1;
      flg_d.inexact  = 1'b1;
`ifdef FMADD_NORM_SUBNORM_EN
    end else if (sub_range) begin
      // A carry into the hidden bit lands on the smallest normal exponent.
      res_d           = '{sign: s1_sign, exp: {7'd0, sub_carry}, mant: sub_mant};
      flg_d.underflow = sub_inexact;
      flg_d.inexact   = sub_inexact;
`endif
    end else if (e_post <= E_ZERO) begin
      res_d           = bf16_zero(s1_sign);
      flg_d.underflow = 1'b1;
      flg_d.inexact   = 1'b1;
    end else begin
      norm_sel      = 1'b1;
      res_d         = '{sign: s1_sign, exp: e_post[7:0], mant: rn_mant_rnd};
      flg_d.inexact = rn_inexact;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe      <= '0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else begin
      if (in_ready) vld_pipe[1] <= in_valid;
      if (s1_adv)   vld_pipe[2] <= vld_pipe[1];
      if (s1_adv && vld_pipe[1]) begin
        out_result    <= res_d;
        out_overflow  <= flg_d.overflow;
        out_underflow <= flg_d.underflow;
        out_inexact   <= flg_d.inexact;
      end
    end
  end

  // Upstream LZD must leave the hidden bit at the MSB for any nonzero, non-special operand.
  a_lzc_consistent: assert property (@(posedge clk) disable iff (rst)
    (vld_pipe[1] && !s1_zero && !s1_special) |-> s1_sh[MAG_W-1]);

  a_norm_exp_range: assert property (@(posedge clk) disable iff (rst)
    (vld_pipe[1] && norm_sel) |->
      ((int'(e_post) - BIAS >= 1 - BF16_BIAS) && (int'(e_post) - BIAS <= BF16_BIAS)));

endmodule

// File: tb/tb_fmadd_norm_round.sv
// Self-checking bench for fmadd_norm_round: directed cases, backpressure, mid-stream reset, random vs value model.
module tb_fmadd_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign, in_special;
  logic [9:0]  in_exp;
  logic [31:0] in_mag;
  logic [4:0]  in_lzc;
  logic [15:0] in_special_val;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic        out_overflow, out_underflow, out_inexact;

  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [31:0] mag;
    logic [4:0]  lzc;
    logic        special;
    logic [15:0] sval;
    logic [15:0] eres;
    logic [2:0]  eflg;
  } item_t;

  logic [18:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fmadd_norm_round dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mag(in_mag), .in_lzc(in_lzc),
    .in_special(in_special), .in_special_val(in_special_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_overflow(out_overflow), .out_underflow(out_underflow), .out_inexact(out_inexact)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [4:0] lzc_of(input logic [31:0] m);
    logic [4:0] n = 5'd0;
    logic found = 1'b0;
    for (int i = 31; i >= 0; i--)
      if (!found && m[i]) begin n = 5'(31 - i); found = 1'b1; end
    return n;
  endfunction

  // Value model: mag * 2^(exp-127-30), rounded to 8 significant bits nearest-even.
  function automatic logic [18:0] model(input logic sign, input int e, input logic [31:0] mag,
                                        input logic sp, input logic [15:0] sv);
    int p = 0, ex, sh;
    longint m, keep, rem, half;
    logic inx = 1'b0, up = 1'b0;
    if (sp) return {3'b000, sv};
    if (mag == 0) return {3'b000, sign, 15'h0};
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    ex = e + p - 30;
    m  = longint'(mag);
    if (p > 7) begin
      sh   = p - 7;
      keep = m >> sh;
      rem  = m & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      up   = (rem > half) || (rem == half && keep[0]);
      inx  = (rem != 0);
    end else begin
      keep = m << (7 - p);
    end
    if (up) keep = keep + 1;
    if (keep == 256) begin keep = 128; ex = ex + 1; end
    if (ex >= 255) return {3'b101, sign, 8'hFF, 7'h00};
    if (ex <= 0)   return {3'b011, sign, 15'h0};
    return {2'b00, inx, sign, ex[7:0], keep[6:0]};
  endfunction

  function automatic item_t mk(input logic sign, input int e, input logic [31:0] mag,
                               input logic sp, input logic [15:0] sv);
    item_t it;
    it.sign = sign; it.exp = e[9:0]; it.mag = mag; it.lzc = lzc_of(mag);
    it.special = sp; it.sval = sv;
    {it.eflg, it.eres} = model(sign, e, mag, sp, sv);
    return it;
  endfunction

  function automatic item_t mkd(input logic sign, input int e, input logic [31:0] mag, input logic sp,
                                input logic [15:0] sv, input logic [15:0] eres, input logic [2:0] eflg);
    item_t it = mk(sign, e, mag, sp, sv);
    it.eres = eres; it.eflg = eflg;
    return it;
  endfunction

  function automatic item_t mk_rand();
    logic [31:0] mag = $urandom >> $urandom_range(0, 31);
    logic [31:0] ones = 32'hFFFF_FFFF;
    if ($urandom_range(0, 3) == 0) mag = mag & (ones << $urandom_range(0, 24));
    if ($urandom_range(0, 11) == 0) mag = 32'h0;
    return mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 300)) - 20, mag,
              $urandom_range(0, 19) == 0, 16'($urandom));
  endfunction

  // One clock: present item, sample acceptance mid-cycle, return just after the edge.
  task automatic cycle_step(input logic v, input item_t it, output logic acc);
    in_valid = v; in_sign = it.sign; in_exp = it.exp; in_mag = it.mag; in_lzc = it.lzc;
    in_special = it.special; in_special_val = it.sval;
    @(negedge clk);
    acc = v && in_ready;
    if (acc) exp_q.push_back({it.eflg, it.eres});
    @(posedge clk); #1;
  endtask

  task automatic send(input item_t it);
    logic acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) cycle_step(1'b1, it, acc);
    chk("send_accept", {31'b0, acc}, 32'd1);
  endtask

  always @(negedge clk) begin
    logic [18:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result", {16'b0, out_result}, {16'b0, e[15:0]});
        chk("flags", {29'b0, out_overflow, out_underflow, out_inexact}, {29'b0, e[18:16]});
      end
    end
  end

  initial begin
    item_t it;
    logic  acc;
    int    idx;
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mag = '0; in_lzc = '0;
    in_special = 1'b0; in_special_val = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", {16'b0, out_result}, 32'd0);
    chk("rst_flags", {29'b0, out_overflow, out_underflow, out_inexact}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // 1.0 and two-cycle latency
    send(mkd(1'b0, 127, 32'h4000_0000, 1'b0, 16'h0, 16'h3F80, 3'b000));
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_cycle2_valid", {31'b0, out_valid}, 32'd1);
    chk("lat_cycle2_result", {16'b0, out_result}, 32'h3F80);
    @(posedge clk); #1;

    // Directed rounding, range and bypass corners, back to back
    send(mkd(1'b0, 127, 32'h40C0_0000, 1'b0, 16'h0, 16'h3F82, 3'b001));
    send(mkd(1'b0, 127, 32'h4040_0000, 1'b0, 16'h0, 16'h3F80, 3'b001));
    send(mkd(1'b0, 127, 32'h4000_0001, 1'b0, 16'h0, 16'h3F80, 3'b001));
    send(mkd(1'b0, 127, 32'hFF80_0000, 1'b0, 16'h0, 16'h4080, 3'b001));
    send(mkd(1'b0, 254, 32'h8000_0000, 1'b0, 16'h0, 16'h7F80, 3'b101));
    send(mkd(1'b0, 253, 32'hFF80_0000, 1'b0, 16'h0, 16'h7F80, 3'b101));
    send(mkd(1'b0, 254, 32'h7F80_0000, 1'b0, 16'h0, 16'h7F7F, 3'b000));
    send(mkd(1'b0,   1, 32'h4000_0000, 1'b0, 16'h0, 16'h0080, 3'b000));
    send(mkd(1'b0,   0, 32'h4000_0000, 1'b0, 16'h0, 16'h0000, 3'b011));
    send(mkd(1'b1,  -5, 32'h4000_0000, 1'b0, 16'h0, 16'h8000, 3'b011));
    send(mkd(1'b1, 130, 32'h6000_0000, 1'b0, 16'h0, 16'hC140, 3'b000));
    send(mkd(1'b1, 127, 32'h0000_0000, 1'b0, 16'h0, 16'h8000, 3'b000));
    send(mkd(1'b0, 127, 32'h1234_5678, 1'b1, 16'h7FC0, 16'h7FC0, 3'b000));
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: out_ready low for 3 cycles while streaming 4 items
    it = mk_rand(); idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
      out_ready = (cyc >= 3);
      cycle_step(1'b1, it, acc);
      if (acc) begin idx++; it = mk_rand(); end
      if (cyc == 2) begin
        chk("bp_in_ready_low", {31'b0, acc}, 32'd0);
        chk("bp_accepted", idx, 32'd2);
        chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_hold_result", {16'b0, out_result}, {16'b0, exp_q[0][15:0]});
        chk("bp_hold_flags", {29'b0, out_overflow, out_underflow, out_inexact}, {29'b0, exp_q[0][18:16]});
      end
    end
    chk("bp_all_accepted", idx, 32'd4);

    // Random traffic with random stalls and bubbles
    it = mk_rand();
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      cycle_step($urandom_range(0, 4) != 0, it, acc);
      if (acc) it = mk_rand();
    end

    // Reset with two items in flight
    out_ready = 1'b1;
    cycle_step(1'b1, mk_rand(), acc);
    cycle_step(1'b1, mk_rand(), acc);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    send(mkd(1'b0, 127, 32'h4000_0000, 1'b0, 16'h0, 16'h3F80, 3'b000));
    in_valid = 1'b0;

    for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
